// File: rtl/ysyx_25030093_pkg.sv
// Shared LSU definitions: FSM states, RV32I load/store funct3 codes and
// legality / alignment / byte-strobe helpers.
package ysyx_25030093_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants exist only for loads.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !is_store;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic addr_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] lane_strobe(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << offset;
            2'b01:   return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_25030093_lsu_align.sv
// Combinational lane logic: store data replication / strobes, access legality,
// and load byte/half extraction with sign or zero extension.
module ysyx_25030093_lsu_align
    import ysyx_25030093_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] lane_wdata,
    output logic [3:0]  lane_wstrb,
    output logic [31:0] load_data,
    output logic        access_fault
);

    logic [31:0] shifted;

    assign access_fault = !funct3_legal(is_store, funct3) || addr_misaligned(funct3, offset);
    assign lane_wstrb   = lane_strobe(funct3, offset);

    // Every lane carries a copy of the datum so the strobe alone picks the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_wdata[gi*8 +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                           (funct3[1:0] == 2'b01) ? wdata[(gi%2)*8 +: 8] :
                                                                    wdata[gi*8 +: 8];
        end
    endgenerate

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   load_data = {24'd0, shifted[7:0]};
            F3_HU:   load_data = {16'd0, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_25030093_lsu.sv
// Load/store unit: accepts one access at a time, runs a req/gnt/rvalid bus
// handshake with a wait-cycle timeout, and holds the result until out_ready.
module ysyx_25030093_lsu
    import ysyx_25030093_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_store,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [4:0]  in_rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        mem_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_fault
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    lsu_state_e    state_reg;
    logic          is_store_reg;
    logic [2:0]    funct3_reg;
    logic [1:0]    offset_reg;
    logic [4:0]    rd_reg;
    logic [CW-1:0] wait_cnt_reg;
    logic [CW-1:0] wait_cnt_next;

    logic          sel_is_store;
    logic [2:0]    sel_funct3;
    logic [1:0]    sel_offset;
    logic [31:0]   lane_wdata;
    logic [3:0]    lane_wstrb;
    logic [31:0]   load_data;
    logic          access_fault;
    logic          timeout;
    logic          resp_wen;
    logic [31:0]   resp_data;

    // In IDLE the aligner looks at the incoming request; afterwards at the latched one.
    assign sel_is_store = (state_reg == ST_IDLE) ? in_is_store   : is_store_reg;
    assign sel_funct3   = (state_reg == ST_IDLE) ? in_funct3     : funct3_reg;
    assign sel_offset   = (state_reg == ST_IDLE) ? in_addr[1:0]  : offset_reg;

    ysyx_25030093_lsu_align u_align (
        .is_store     (sel_is_store),
        .funct3       (sel_funct3),
        .offset       (sel_offset),
        .wdata        (in_wdata),
        .rdata        (mem_rdata),
        .lane_wdata   (lane_wdata),
        .lane_wstrb   (lane_wstrb),
        .load_data    (load_data),
        .access_fault (access_fault)
    );

    assign wait_cnt_next = (wait_cnt_reg == CNT_MAX) ? wait_cnt_reg : wait_cnt_reg + 1'b1;
    assign timeout       = (wait_cnt_reg >= CNT_LAST);
    assign resp_wen      = !is_store_reg && !mem_err && (rd_reg != 5'd0);
    assign resp_data     = (is_store_reg || mem_err) ? 32'd0 : load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            is_store_reg <= 1'b0;
            funct3_reg   <= 3'd0;
            offset_reg   <= 2'd0;
            rd_reg       <= 5'd0;
            wait_cnt_reg <= '0;
            in_ready     <= 1'b1;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
            mem_wstrb    <= 4'd0;
            out_valid    <= 1'b0;
            out_data     <= 32'd0;
            out_rd       <= 5'd0;
            out_wen      <= 1'b0;
            out_fault    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        is_store_reg <= in_is_store;
                        funct3_reg   <= in_funct3;
                        offset_reg   <= in_addr[1:0];
                        rd_reg       <= in_rd;
                        wait_cnt_reg <= '0;
                        in_ready     <= 1'b0;
                        out_rd       <= in_rd;
                        if (access_fault) begin
                            state_reg <= ST_DONE;
                            out_valid <= 1'b1;
                            out_fault <= 1'b1;
                            out_wen   <= 1'b0;
                            out_data  <= 32'd0;
                        end else begin
                            state_reg <= ST_REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= in_is_store;
                            mem_addr  <= {in_addr[31:2], 2'b00};
                            mem_wdata <= in_is_store ? lane_wdata : 32'd0;
                            mem_wstrb <= in_is_store ? lane_wstrb : 4'd0;
                        end
                    end
                end
                ST_REQ, ST_RESP: begin
                    wait_cnt_reg <= wait_cnt_next;
                    // A grant or response in the last allowed cycle wins over the timeout.
                    if (state_reg == ST_REQ && mem_gnt) begin
                        mem_req <= 1'b0;
                        if (mem_rvalid) begin
                            state_reg <= ST_DONE;
                            out_valid <= 1'b1;
                            out_fault <= mem_err;
                            out_wen   <= resp_wen;
                            out_data  <= resp_data;
                        end else begin
                            state_reg <= ST_RESP;
                        end
                    end else if (state_reg == ST_RESP && mem_rvalid) begin
                        state_reg <= ST_DONE;
                        out_valid <= 1'b1;
                        out_fault <= mem_err;
                        out_wen   <= resp_wen;
                        out_data  <= resp_data;
                    end else if (timeout) begin
                        state_reg <= ST_DONE;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_fault <= 1'b1;
                        out_wen   <= 1'b0;
                        out_data  <= 32'd0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_reg <= ST_IDLE;
                        out_valid <= 1'b0;
                        out_wen   <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25030093_lsu.sv
// Self-checking bench for the LSU: directed spec scenarios plus randomized
// accesses checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ysyx_25030093_lsu;

    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_is_store = 1'b0;
    logic [2:0]  in_funct3 = 3'd0;
    logic [31:0] in_addr = 32'd0;
    logic [31:0] in_wdata = 32'd0;
    logic [4:0]  in_rd = 5'd0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_fault;

    int checks = 0;
    int errors = 0;

    ysyx_25030093_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_store(in_is_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_err(mem_err),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_rd(out_rd), .out_wen(out_wen), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish got timeout exp finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int m_size(input bit [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input bit st, input bit [2:0] f3);
        if (st) return f3 <= 3'd2;
        return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    endfunction

    function automatic bit [31:0] m_wdata(input int sz, input bit [31:0] wd);
        if (sz == 1) return {4{wd[7:0]}};
        if (sz == 2) return {2{wd[15:0]}};
        return wd;
    endfunction

    function automatic bit [3:0] m_wstrb(input int sz, input int off);
        int v;
        v = ((1 << sz) - 1) << off;
        return v[3:0];
    endfunction

    function automatic bit [31:0] m_load(input bit [2:0] f3, input int off, input bit [31:0] word);
        int sz;
        bit [31:0] mask, val;
        sz = m_size(f3);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        val = (word >> (8 * off)) & mask;
        if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
        return val;
    endfunction

    // ---------------- one complete transaction ----------------
    // gd: cycles in REQ before mem_gnt; rdly: cycles after gnt until rvalid (0 = same cycle).
    task automatic do_txn(input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                          input bit [4:0] rdst, input int gd, input int rdly, input bit err,
                          input bit [31:0] rdat, input int rdy);
        int sz, off;
        bit mfault, tmo, got_gnt, got_rsp, e_fault, e_wen;
        bit [31:0] e_wd, e_data;
        bit [3:0] e_strb;
        sz = m_size(f3);
        off = a % 4;
        mfault = !m_legal(st, f3) || (off % sz != 0);
        e_wd = m_wdata(sz, wd);
        e_strb = st ? m_wstrb(sz, off) : 4'd0;
        tmo = 0; got_gnt = 0; got_rsp = 0;

        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b exp 1", in_ready); end
        in_valid = 1; in_is_store = st; in_funct3 = f3; in_addr = a; in_wdata = wd; in_rd = rdst;
        @(posedge clk); #1;
        // Scramble the request fields: the latched copy must be what is used.
        in_valid = 1'($urandom_range(0, 1)); in_is_store = 1'($urandom_range(0, 1));
        in_funct3 = 3'($urandom_range(0, 7)); in_addr = $urandom; in_wdata = $urandom;
        in_rd = 5'($urandom_range(0, 31));

        if (!mfault) begin
            for (int n = 0; n < TMO; n++) begin
                checks++;
                if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== {a[31:2], 2'b00} ||
                    mem_wstrb !== e_strb || (st && mem_wdata !== e_wd) || out_valid !== 1'b0 || in_ready !== 1'b0)
                    begin errors++; $display("FAIL req_phase got req=%b we=%b addr=%h wd=%h strb=%b ov=%b ir=%b exp req=1 we=%b addr=%h wd=%h strb=%b ov=0 ir=0",
                        mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, out_valid, in_ready, st, {a[31:2], 2'b00}, e_wd, e_strb); end
                if (n == gd) begin
                    mem_gnt = 1;
                    if (rdly == 0) begin mem_rvalid = 1; mem_err = err; mem_rdata = rdat; end
                end
                @(posedge clk); #1;
                mem_gnt = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
                if (n == gd) begin got_gnt = 1; got_rsp = (rdly == 0); break; end
            end
            if (!got_gnt) tmo = 1;
            if (got_gnt && !got_rsp) begin
                for (int k = 1; k <= TMO; k++) begin
                    checks++;
                    if (mem_req !== 1'b0 || out_valid !== 1'b0)
                        begin errors++; $display("FAIL resp_phase got req=%b ov=%b exp req=0 ov=0", mem_req, out_valid); end
                    if (k == rdly) begin mem_rvalid = 1; mem_err = err; mem_rdata = rdat; end
                    @(posedge clk); #1;
                    mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
                    if (k == rdly) begin got_rsp = 1; break; end
                    if (gd + k >= TMO - 1) break;
                end
                if (!got_rsp) tmo = 1;
            end
        end

        e_fault = mfault || tmo || err;
        e_wen = !st && !e_fault && (rdst != 5'd0);
        e_data = (st || e_fault) ? 32'd0 : m_load(f3, off, rdat);
        in_valid = 0;

        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL done_valid got %b exp 1", out_valid); end
        checks++;
        if (out_fault !== e_fault) begin errors++; $display("FAIL done_fault got %b exp %b", out_fault, e_fault); end
        checks++;
        if (out_wen !== e_wen) begin errors++; $display("FAIL done_wen got %b exp %b", out_wen, e_wen); end
        checks++;
        if (out_data !== e_data) begin errors++; $display("FAIL done_data got %h exp %h", out_data, e_data); end
        checks++;
        if (out_rd !== rdst || mem_req !== 1'b0)
            begin errors++; $display("FAIL done_rd got rd=%0d req=%b exp rd=%0d req=0", out_rd, mem_req, rdst); end

        for (int k = 0; k < rdy; k++) begin
            out_ready = 0;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== e_data || out_fault !== e_fault || out_wen !== e_wen || out_rd !== rdst)
                begin errors++; $display("FAIL hold_stable got ov=%b data=%h fault=%b wen=%b exp ov=1 data=%h fault=%b wen=%b",
                    out_valid, out_data, out_fault, out_wen, e_data, e_fault, e_wen); end
        end
        out_ready = 1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL done_in_ready got %b exp 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end

        $display("TXN st=%0d f3=%0d addr=%h wd=%h rd=%0d gd=%0d rdly=%0d err=%0d -> data=%h wen=%0d fault=%0d",
                 st, f3, a, wd, rdst, gd, rdly, err, e_data, e_wen, e_fault);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb} !== 70'd0)
            begin errors++; $display("FAIL reset_mem got req=%b we=%b addr=%h wd=%h strb=%b exp all 0",
                mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
        checks++;
        if ({out_valid, out_data, out_rd, out_wen, out_fault} !== 40'd0)
            begin errors++; $display("FAIL reset_out got ov=%b data=%h rd=%0d wen=%b fault=%b exp all 0",
                out_valid, out_data, out_rd, out_wen, out_fault); end
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin errors++; $display("FAIL post_reset got ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
        $display("TXN reset");
    endtask

    task automatic test_directed();
        do_txn(1, 3'b010, 32'h8000_0004, 32'h1122_3344, 5'd0, 2, 1, 0, 32'h0, 0);       // SW
        do_txn(0, 3'b000, 32'h8000_0003, 32'h0, 5'd5, 0, 0, 0, 32'h80FF_0000, 0);      // LB, 2-cycle latency
        do_txn(0, 3'b101, 32'h8000_0002, 32'h0, 5'd7, 1, 1, 0, 32'hBEEF_1234, 0);      // LHU
        do_txn(1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 5'd1, 0, 1, 0, 32'h0, 0);      // SB
        do_txn(1, 3'b001, 32'h8000_0006, 32'h0000_CAFE, 5'd2, 0, 0, 0, 32'h0, 0);      // SH upper half
        do_txn(0, 3'b010, 32'h8000_0002, 32'h0, 5'd9, 0, 0, 0, 32'h0, 1);              // LW misaligned
        do_txn(0, 3'b011, 32'h8000_0000, 32'h0, 5'd9, 0, 0, 0, 32'h0, 0);              // illegal funct3
        do_txn(1, 3'b001, 32'h8000_0003, 32'h0, 5'd3, 0, 0, 0, 32'h0, 0);              // SH misaligned
        do_txn(1, 3'b100, 32'h8000_0000, 32'h0, 5'd3, 0, 0, 0, 32'h0, 0);              // store 100 illegal
        do_txn(0, 3'b010, 32'h8000_0010, 32'h0, 5'd4, 1000, 0, 0, 32'h0, 0);           // gnt timeout
        do_txn(0, 3'b010, 32'h8000_0010, 32'h0, 5'd4, 0, 1000, 0, 32'h0, 0);           // rvalid timeout
        do_txn(0, 3'b010, 32'h8000_0014, 32'h0, 5'd4, TMO - 1, 0, 0, 32'h1234_5678, 0); // gnt in last cycle
        do_txn(0, 3'b010, 32'h8000_0018, 32'h0, 5'd6, 1, 1, 1, 32'hDEAD_BEEF, 0);      // bus error
        do_txn(0, 3'b010, 32'h8000_001C, 32'h0, 5'd8, 0, 2, 0, 32'hA5A5_5A5A, 5);      // out_ready held low
        do_txn(0, 3'b001, 32'h8000_0002, 32'h0, 5'd0, 0, 0, 0, 32'h8001_0000, 0);      // LH to x0
    endtask

    task automatic test_no_bypass();
        in_valid = 1; in_is_store = 0; in_funct3 = 3'b010; in_addr = 32'h8000_0002; in_rd = 5'd1;
        @(posedge clk); #1;
        out_ready = 1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin errors++; $display("FAIL bypass_done got ov=%b ir=%b exp ov=1 ir=0", out_valid, in_ready); end
        @(posedge clk); #1;
        out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL no_bypass got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (out_valid !== 1'b1 || out_fault !== 1'b1)
            begin errors++; $display("FAIL bypass_next got ov=%b fault=%b exp ov=1 fault=1", out_valid, out_fault); end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        $display("TXN no_bypass");
    endtask

    task automatic test_reset_mid();
        // Reset while REQ is outstanding: mem_req must fall without a clock edge.
        in_valid = 1; in_is_store = 0; in_funct3 = 3'b010; in_addr = 32'h8000_0020; in_rd = 5'd3;
        @(posedge clk); #1;
        in_valid = 0;
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL mid_req_up got %b exp 1", mem_req); end
        rst = 1; #1;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rst_in_req got req=%b ir=%b exp req=0 ir=1", mem_req, in_ready); end
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        // Reset while in RESP, then a stray late response.
        in_valid = 1; in_is_store = 0; in_funct3 = 3'b010; in_addr = 32'h8000_0024; in_rd = 5'd3;
        @(posedge clk); #1;
        in_valid = 0; mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0)
            begin errors++; $display("FAIL mid_resp got ir=%b ov=%b exp ir=0 ov=0", in_ready, out_valid); end
        rst = 1; #1;
        checks++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1)
            begin errors++; $display("FAIL rst_in_resp got req=%b ir=%b exp req=0 ir=1", mem_req, in_ready); end
        @(posedge clk); #1;
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        mem_rvalid = 0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1)
                begin errors++; $display("FAIL stray_rvalid got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
            @(posedge clk); #1;
        end
        $display("TXN reset_mid");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            bit st;
            bit [2:0] f3;
            bit [31:0] a;
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'($urandom_range(0, 3));
            do_txn(st, f3, a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                   $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom, $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_no_bypass();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25030093_lsu.md
YSYX_25030093_LSU -- requirements
Module: ysyx_25030093_LSU

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, max cycles waiting in REQ or RESP before a bus fault.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  execute-stage request valid.
REQ-005 SHALL have port in_ready  out  1  LSU can accept a request.
REQ-006 SHALL have port in_is_store  in  1  1 = store, 0 = load.
REQ-007 SHALL have port in_funct3  in  3  access size/sign (RV32I encoding).
REQ-008 SHALL have port in_addr  in  32  byte address from ALU (rs1+imm).
REQ-009 SHALL have port in_wdata  in  32  store data (rs2).
REQ-010 SHALL have port in_rd  in  5  load destination register.
REQ-011 SHALL have port mem_req  out  1  bus request.
REQ-012 SHALL have port mem_we  out  1  bus write enable.
REQ-013 SHALL have port mem_addr  out  32  word-aligned bus address.
REQ-014 SHALL have port mem_wdata  out  32  lane-shifted store data.
REQ-015 SHALL have port mem_wstrb  out  4  byte strobes.
REQ-016 SHALL have ports mem_gnt in 1 (request accepted), mem_rvalid in 1 (response), mem_rdata in 32, mem_err in 1 (bus error with response).
REQ-017 SHALL have ports out_valid out 1, out_ready in 1, out_data out 32, out_rd out 5, out_wen out 1 (regfile write), out_fault out 1.

Function
REQ-018 SHALL implement FSM IDLE, REQ, RESP, DONE; in_ready=1 only in IDLE.
REQ-019 On in_valid&&in_ready SHALL latch all in_* fields; later in_* changes have no effect.
REQ-020 Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW; any other value is illegal.
REQ-021 Misaligned (LH/SH addr[0]=1; LW/SW addr[1:0]!=0) or illegal funct3 SHALL go IDLE->DONE with out_fault=1 and no mem_req.
REQ-022 Otherwise IDLE->REQ; mem_req=1 from the cycle after acceptance, held with stable addr/we/wdata/wstrb until mem_gnt.
REQ-023 mem_addr = {addr[31:2],2'b00}; stores: wdata replicated per lane (SB byte x4, SH half x2), wstrb = 0001<<addr[1:0], 0011<<addr[1:0], or 1111; loads: wstrb=0000.
REQ-024 REQ->RESP on mem_gnt; if mem_rvalid also high that cycle, REQ->DONE directly capturing the response.
REQ-025 RESP->DONE on mem_rvalid; mem_rvalid outside REQ/RESP SHALL be ignored.
REQ-026 Load data: select byte/half by addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU; out_data=0 for stores and faults.
REQ-027 out_wen=1 only for a non-faulting load with rd!=0; out_rd = latched rd.
REQ-028 mem_err with mem_rvalid, or a wait counter reaching TIMEOUT_CYCLES in REQ/RESP, SHALL set out_fault=1, out_wen=0, go to DONE.
REQ-029 Wait counter SHALL clear on acceptance and count each cycle in REQ or RESP, saturating.
REQ-030 DONE: out_valid=1 with stable outputs until out_ready; DONE->IDLE on out_ready; minimum acceptance-to-out_valid latency is 2 cycles.
REQ-031 New request not accepted in the DONE->IDLE cycle (no bypass); next accept earliest one cycle later.

Reset
REQ-032 rst SHALL asynchronously force IDLE and clear in_ready-related state; outputs: in_ready=1 after reset, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, out_valid=0, out_data=0, out_rd=0, out_wen=0, out_fault=0, counter=0.
REQ-033 Reset mid-transaction SHALL drop mem_req immediately; a late response after reset is ignored per REQ-025.

Structure
REQ-034 FSM state enum, funct3 encodings and lane/strobe helpers SHALL live in shared package ysyx_25030093_pkg.
REQ-035 One sub-module ysyx_25030093_LSU_align (combinational store lane/strobe and load extract/extend) is natural; the FSM stays in the top.

Verification
REQ-036 SW addr 0x80000004 data 0x11223344, gnt after 2 cycles -> mem_addr 0x80000004, wstrb 1111, out_valid, out_wen=0, no fault.
REQ-037 LB addr 0x80000003, rdata 0x80FF0000, gnt+rvalid same cycle -> out_data 0xFFFFFF80, out_wen=1, out_valid 2 cycles after accept.
REQ-038 LHU addr 0x80000002, rdata 0xBEEF1234 -> out_data 0x0000BEEF; SB addr ...01 data 0xAB -> wdata 0xABABABAB, wstrb 0010.
REQ-039 LW addr 0x80000002 -> no mem_req, out_fault=1, out_wen=0; funct3 011 load -> same.
REQ-040 No gnt for TIMEOUT_CYCLES -> out_fault=1; mem_err with rvalid -> out_fault=1; out_ready held low 5 cycles -> outputs stable.
REQ-041 rst asserted while in RESP -> mem_req=0 and in_ready=1 immediately; stray rvalid next cycle -> no out_valid.
